// File: rtl/rv32_lsu_if.sv
// Core/RAM-facing bundle of the rv32_lsu: request, response and data-RAM signals.
// The slave modport is the LSU side; the master modport is the core plus RAM side.
interface rv32_lsu_if #(
    parameter int MEM_AW = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_memop;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_memop, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_memop, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/rv32_lsu.sv
// RV32I load/store unit against a word-wide synchronous RAM without byte enables.
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
module rv32_lsu #(
    parameter int MEM_AW = 16
) (
    input  logic      i_clock,
    input  logic      i_reset,
    rv32_lsu_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RWAIT = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              w_accept;
    logic              w_req_err;
    logic              r_we;
    logic [2:0]        r_memop;
    logic [1:0]        r_off;
    logic [15:0]       r_wdata;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_req_ready_nxt;
    logic              w_resp_valid_nxt;
    logic              w_resp_err_nxt;
    logic [31:0]       w_resp_rdata_nxt;
    logic              w_mem_re_nxt;
    logic              w_mem_we_nxt;

    logic              w_unused_addr;

    // Illegal encodings, loads-only encodings used for stores, and misalignment.
    function automatic logic f_req_err(input logic we, input logic [2:0] memop,
                                       input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal    = (memop == 3'b011) || (memop == 3'b110) || (memop == 3'b111) ||
                     (we && memop[2]);
        misaligned = ((memop[1:0] == 2'b01) && addr_lo[0]) ||
                     ((memop == 3'b010) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

    function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [2:0] memop,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (memop)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [15:0] data,
                                            input logic [2:0] memop, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        case (memop[1:0])
            2'b00: begin
                case (off)
                    2'b00:   res[7:0]   = data[7:0];
                    2'b01:   res[15:8]  = data[7:0];
                    2'b10:   res[23:16] = data[7:0];
                    2'b11:   res[31:24] = data[7:0];
                    default: res        = word;
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    res[31:16] = data;
                end else begin
                    res[15:0] = data;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Address bits above the RAM window alias and are deliberately dropped.
    assign w_unused_addr = ^bus.req_addr[31:MEM_AW+2];

    assign w_accept  = r_req_ready & bus.req_valid;
    assign w_req_err = f_req_err(bus.req_we, bus.req_memop, bus.req_addr[1:0]);

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; errors skip straight to the response.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_accept) begin
                    w_state_nxt = S_IDLE;
                end else if (w_req_err) begin
                    w_state_nxt = S_RESP;
                end else if (bus.req_we && (bus.req_memop == 3'b010)) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ:  w_state_nxt = S_RWAIT;
            S_RWAIT: w_state_nxt = r_we ? S_WRITE : S_RESP;
            S_WRITE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode, looking one state ahead so every output leaves a flop.
    always_comb begin
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
        w_mem_re_nxt     = (w_state_nxt == S_READ);
        w_mem_we_nxt     = (w_state_nxt == S_WRITE);
        w_resp_valid_nxt = (w_state_nxt == S_RESP);
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = 32'h00000000;
        if ((r_state == S_IDLE) && w_accept && w_req_err) begin
            w_resp_err_nxt = 1'b1;
        end else begin
            w_resp_err_nxt = 1'b0;
        end
        if ((r_state == S_RWAIT) && !r_we) begin
            w_resp_rdata_nxt = f_extend(bus.mem_rdata, r_memop, r_off);
        end else begin
            w_resp_rdata_nxt = 32'h00000000;
        end
    end

    // Registered handshake, response and RAM strobes.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h00000000;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_mem_re     <= w_mem_re_nxt;
            r_mem_we     <= w_mem_we_nxt;
        end
    end

    // Request capture and RAM word/address; the merged word only reaches the RAM in WRITE.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_we        <= 1'b0;
            r_memop     <= 3'b000;
            r_off       <= 2'b00;
            r_wdata     <= 16'h0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h00000000;
        end else if (w_accept && !w_req_err) begin
            r_we       <= bus.req_we;
            r_memop    <= bus.req_memop;
            r_off      <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata[15:0];
            r_mem_addr <= bus.req_addr[MEM_AW+1:2];
            if (bus.req_we) begin
                r_mem_wdata <= bus.req_wdata;
            end
        end else if ((r_state == S_RWAIT) && r_we) begin
            r_mem_wdata <= f_merge(bus.mem_rdata, r_wdata, r_memop, r_off);
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_re     = r_mem_re;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_rv32_lsu.sv
// Bench for rv32_lsu: directed scenarios plus randomized traffic scored against
// a word-array memory model that applies the load/store rules arithmetically.
module tb_rv32_lsu;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32_lsu_if #(.MEM_AW(16)) bus_if ();

    rv32_lsu #(.MEM_AW(16)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus_if.slave)
    );

    logic [31:0] ram [0:65535];

    // Synchronous word RAM: write on mem_we, read data one cycle after mem_re.
    always @(posedge clk) begin
        if (bus_if.mem_we) ram[bus_if.mem_addr] <= bus_if.mem_wdata;
        if (bus_if.mem_re) bus_if.mem_rdata <= ram[bus_if.mem_addr];
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] we_data;
    logic [15:0] we_addr;
    logic [31:0] got;

    int b2b_ready [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int b2b_valid [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int b2b_re    [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    int b2b_addr  [8] = '{4, 4, 4, 4, 8, 8, 8, 8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: decides error/latency/result from the rules and updates the word array.
    function automatic void model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic err, output int lat,
                                  output logic [31:0] rd, output int n_re, output int n_we);
        int          idx;
        int          bsh;
        int          hsh;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        logic        illegal;
        logic        mis;
        idx     = int'(addr[17:2]);
        bsh     = 8 * int'(addr[1:0]);
        hsh     = 16 * int'(addr[1]);
        illegal = (op == 3'd3) || (op == 3'd6) || (op == 3'd7) || (we && op >= 3'd4);
        mis     = ((op == 3'd1 || op == 3'd5) && addr[0]) || (op == 3'd2 && addr[1:0] != 2'd0);
        err     = illegal || mis;
        rd      = 32'd0;
        if (err) begin
            lat = 1; n_re = 0; n_we = 0;
        end else if (!we) begin
            lat = 3; n_re = 1; n_we = 0;
            w = ref_mem[idx];
            if (op == 3'd0 || op == 3'd4) begin
                v = (w >> bsh) & 32'hFF;
                rd = (op == 3'd0 && v >= 32'd128) ? v - 32'd256 : v;
            end else if (op == 3'd1 || op == 3'd5) begin
                v = (w >> hsh) & 32'hFFFF;
                rd = (op == 3'd1 && v >= 32'd32768) ? v - 32'd65536 : v;
            end else begin
                rd = w;
            end
        end else if (op == 3'd2) begin
            lat = 2; n_re = 0; n_we = 1;
            ref_mem[idx] = wd;
        end else begin
            lat = 4; n_re = 1; n_we = 1;
            if (op == 3'd0) begin
                mask = 32'hFF << bsh;
                ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd & 32'hFF) << bsh);
            end else begin
                mask = 32'hFFFF << hsh;
                ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd & 32'hFFFF) << hsh);
            end
        end
    endfunction

    // One request issued at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
    task automatic txn(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd_o);
        logic        e_err;
        int          e_lat;
        logic [31:0] e_rd;
        int          e_re;
        int          e_we;
        int          lat = 0;
        int          nre = 0;
        int          nwe = 0;
        int          busy_ready = 0;
        logic        err_o = 1'b0;
        rd_o = 32'd0;
        model(we, op, addr, wd, e_err, e_lat, e_rd, e_re, e_we);
        chk({tag, "/ready_idle"}, {31'd0, bus_if.req_ready}, 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_memop = op;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = 32'hFFFF_FFFF;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            if (bus_if.mem_re) nre++;
            if (bus_if.mem_we) begin
                nwe++;
                we_addr = bus_if.mem_addr;
                we_data = bus_if.mem_wdata;
            end
            if (bus_if.req_ready) busy_ready++;
            if (bus_if.resp_valid) begin
                lat   = c;
                err_o = bus_if.resp_err;
                rd_o  = bus_if.resp_rdata;
            end
            @(negedge clk);
        end
        chk({tag, "/latency"}, lat, e_lat);
        chk({tag, "/err"}, {31'd0, err_o}, {31'd0, e_err});
        chk({tag, "/rdata"}, rd_o, e_rd);
        chk({tag, "/mem_re_cycles"}, nre, e_re);
        chk({tag, "/mem_we_cycles"}, nwe, e_we);
        chk({tag, "/ready_busy"}, busy_ready, 32'd0);
        chk({tag, "/resp_single"}, {31'd0, bus_if.resp_valid}, 32'd0);
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_memop = 3'd0;
        bus_if.req_addr  = 32'd0;
        bus_if.req_wdata = 32'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst/req_ready", {31'd0, bus_if.req_ready}, 32'd0);
        chk("rst/resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        chk("rst/resp_err", {31'd0, bus_if.resp_err}, 32'd0);
        chk("rst/resp_rdata", bus_if.resp_rdata, 32'd0);
        chk("rst/mem_re", {31'd0, bus_if.mem_re}, 32'd0);
        chk("rst/mem_we", {31'd0, bus_if.mem_we}, 32'd0);
        chk("rst/mem_addr", {16'd0, bus_if.mem_addr}, 32'd0);
        chk("rst/mem_wdata", bus_if.mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst/ready_after", {31'd0, bus_if.req_ready}, 32'd1);

        // Word store then load.
        txn("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
        chk("sw10/mem_addr", {16'd0, we_addr}, 32'd4);
        chk("sw10/mem_wdata", we_data, 32'hDEADBEEF);
        txn("lw10", 1'b0, 3'd2, 32'h10, 32'd0, got);
        chk("lw10/value", got, 32'hDEADBEEF);

        // Byte store read-modify-write.
        txn("pre4a", 1'b1, 3'd2, 32'h10, 32'h11223344, got);
        txn("sb13", 1'b1, 3'd0, 32'h13, 32'h000000A5, got);
        chk("sb13/ram", ram[4], 32'hA5223344);
        txn("lb13", 1'b0, 3'd0, 32'h13, 32'd0, got);
        chk("lb13/value", got, 32'hFFFFFFA5);
        txn("lbu13", 1'b0, 3'd4, 32'h13, 32'd0, got);
        chk("lbu13/value", got, 32'h000000A5);

        // Halfword store read-modify-write.
        txn("pre4b", 1'b1, 3'd2, 32'h10, 32'h11223344, got);
        txn("sh12", 1'b1, 3'd1, 32'h12, 32'h12348001, got);
        chk("sh12/ram", ram[4], 32'h80013344);
        txn("lh12", 1'b0, 3'd1, 32'h12, 32'd0, got);
        chk("lh12/value", got, 32'hFFFF8001);
        txn("lhu12", 1'b0, 3'd5, 32'h12, 32'd0, got);
        chk("lhu12/value", got, 32'h00008001);
        txn("lh10", 1'b0, 3'd1, 32'h10, 32'd0, got);
        chk("lh10/value", got, 32'h00003344);

        // Error responses.
        txn("err_lw11", 1'b0, 3'd2, 32'h11, 32'd0, got);
        txn("err_sh13", 1'b1, 3'd1, 32'h13, 32'hFFFF, got);
        txn("err_ld011", 1'b0, 3'd3, 32'h10, 32'd0, got);
        txn("err_st100", 1'b1, 3'd4, 32'h10, 32'h77, got);
        chk("err/ram_kept", ram[4], 32'h80013344);

        // Reset during the RWAIT cycle of a byte store.
        txn("pre8", 1'b1, 3'd2, 32'h20, 32'h55667788, got);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_memop = 3'd0;
        bus_if.req_addr  = 32'h21;
        bus_if.req_wdata = 32'hCC;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk("rstmid/mem_re_read", {31'd0, bus_if.mem_re}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid/mem_re", {31'd0, bus_if.mem_re}, 32'd0);
        chk("rstmid/mem_we", {31'd0, bus_if.mem_we}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid/no_resp", {31'd0, bus_if.resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid/ram_kept", ram[8], 32'h55667788);
        chk("rstmid/ready", {31'd0, bus_if.req_ready}, 32'd1);
        txn("rstmid_lw", 1'b0, 3'd2, 32'h20, 32'd0, got);
        chk("rstmid_lw/value", got, 32'h55667788);

        // req_valid held high with a new load every cycle.
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b0;
        bus_if.req_memop = 3'd2;
        bus_if.req_addr  = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("b2b/ready_c%0d", c), {31'd0, bus_if.req_ready}, b2b_ready[c-1]);
            chk($sformatf("b2b/valid_c%0d", c), {31'd0, bus_if.resp_valid}, b2b_valid[c-1]);
            chk($sformatf("b2b/mem_re_c%0d", c), {31'd0, bus_if.mem_re}, b2b_re[c-1]);
            chk($sformatf("b2b/mem_addr_c%0d", c), {16'd0, bus_if.mem_addr}, b2b_addr[c-1]);
            if (c == 3) chk("b2b/rdata1", bus_if.resp_rdata, ref_mem[4]);
            if (c == 7) chk("b2b/rdata2", bus_if.resp_rdata, ref_mem[8]);
            bus_if.req_addr = 32'h20 + 32'(c) * 32'h40000;
            if (c == 8) bus_if.req_valid = 1'b0;
        end

        // Randomized traffic over 16 aliased words.
        for (int i = 0; i < 16; i++) begin
            txn("rinit", 1'b1, 3'd2, {14'($urandom_range(0, 16383)), 12'd0, 4'(i), 2'd0},
                $urandom, got);
        end
        for (int i = 0; i < 60; i++) begin
            txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                {14'($urandom_range(0, 16383)), 12'd0, 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3))}, $urandom, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
